// File: rtl/conv_host_pkg.sv
// Shared types and default sizes for the conv stream host.
// Imported by the host top and its frame buffer.
package conv_host_pkg;

    typedef enum logic [1:0] {
        LOAD,
        SEND,
        COLLECT,
        DRAIN
    } host_state_t;

    localparam int WIDTH_DEF = 8;
    localparam int LENX_DEF  = 8;
    localparam int LENY_DEF  = 5;
    localparam int LOGX_DEF  = 3;
    localparam int LOGY_DEF  = 3;

endpackage

// File: rtl/host_frame_buf.sv
// Register-array frame buffer.
// One synchronous write port, one combinational read port.
module host_frame_buf
    import conv_host_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int DEPTH = LENX_DEF,
    parameter int LOGD  = LOGX_DEF
) (
    input  logic             clk,
    input  logic             we_i,
    input  logic [LOGD-1:0]  waddr_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic [LOGD-1:0]  raddr_i,
    output logic [WIDTH-1:0] rdata_o
);

    logic [WIDTH-1:0] mem_q [DEPTH];

    // Contents need no reset: a slot is always written before it is read.
    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem_q[raddr_i];

endmodule

// File: rtl/conv_stream_host.sv
// Host endpoint: load a frame, stream it to a conv engine,
// collect the engine results and present them on a readout port.
module conv_stream_host
    import conv_host_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEF,
    parameter int LENX  = LENX_DEF,
    parameter int LENY  = LENY_DEF,
    parameter int LOGX  = LOGX_DEF,
    parameter int LOGY  = LOGY_DEF
) (
    input  logic             clk,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] ld_data,
    input  logic             ld_valid,
    output logic             ld_ready,
    output logic [WIDTH-1:0] m_data_out_x,
    output logic             m_valid_x,
    input  logic             m_ready_x,
    input  logic [WIDTH-1:0] s_data_in_y,
    input  logic             s_valid_y,
    output logic             s_ready_y,
    output logic [WIDTH-1:0] rd_data,
    output logic             rd_valid,
    input  logic             rd_ready,
    output logic [15:0]      frames_done
);

    host_state_t state_q, state_d;
    logic [LOGX-1:0] ld_cnt_q, ld_cnt_d;
    logic [LOGX-1:0] tx_cnt_q, tx_cnt_d;
    logic [LOGY-1:0] rx_cnt_q, rx_cnt_d;
    logic [LOGY-1:0] rd_cnt_q, rd_cnt_d;
    logic [15:0]     frames_q, frames_d;
    logic            armed_q, armed_d;
    logic            y_full_q, y_full_d;

    logic ld_fire, x_fire, y_fire, rd_fire;
    logic [WIDTH-1:0] x_rd, y_rd;

    // Valids are pure state decodes; ld_ready waits one edge after reset.
    assign ld_ready  = armed_q && (state_q == LOAD);
    assign m_valid_x = (state_q == SEND);
    assign s_ready_y = ((state_q == SEND) || (state_q == COLLECT))
                       && !y_full_q;
    assign rd_valid  = (state_q == DRAIN);

    assign ld_fire = ld_valid && ld_ready;
    assign x_fire  = m_valid_x && m_ready_x;
    assign y_fire  = s_valid_y && s_ready_y;
    assign rd_fire = rd_valid && rd_ready;

    assign m_data_out_x = m_valid_x ? x_rd : '0;
    assign rd_data      = rd_valid ? y_rd : '0;
    assign frames_done  = frames_q;

    host_frame_buf #(
        .WIDTH (WIDTH),
        .DEPTH (LENX),
        .LOGD  (LOGX)
    ) u_xbuf (
        .clk     (clk),
        .we_i    (ld_fire),
        .waddr_i (ld_cnt_q),
        .wdata_i (ld_data),
        .raddr_i (tx_cnt_q),
        .rdata_o (x_rd)
    );

    host_frame_buf #(
        .WIDTH (WIDTH),
        .DEPTH (LENY),
        .LOGD  (LOGY)
    ) u_ybuf (
        .clk     (clk),
        .we_i    (y_fire),
        .waddr_i (rx_cnt_q),
        .wdata_i (s_data_in_y),
        .raddr_i (rd_cnt_q),
        .rdata_o (y_rd)
    );

    // Next state and counters; y beats are counted in SEND and COLLECT.
    always_comb begin
        state_d  = state_q;
        ld_cnt_d = ld_cnt_q;
        tx_cnt_d = tx_cnt_q;
        rx_cnt_d = rx_cnt_q;
        rd_cnt_d = rd_cnt_q;
        frames_d = frames_q;
        armed_d  = 1'b1;
        y_full_d = y_full_q;

        unique case (state_q)
            LOAD: begin
                if (ld_fire) begin
                    if (ld_cnt_q == LOGX'(LENX - 1)) begin
                        ld_cnt_d = '0;
                        state_d  = SEND;
                    end else begin
                        ld_cnt_d = ld_cnt_q + LOGX'(1);
                    end
                end
            end
            SEND: begin
                if (x_fire) begin
                    if (tx_cnt_q == LOGX'(LENX - 1)) begin
                        tx_cnt_d = '0;
                        state_d  = COLLECT;
                    end else begin
                        tx_cnt_d = tx_cnt_q + LOGX'(1);
                    end
                end
            end
            COLLECT: begin
                if (y_full_q) begin
                    y_full_d = 1'b0;
                    state_d  = DRAIN;
                end
            end
            DRAIN: begin
                if (rd_fire) begin
                    if (rd_cnt_q == LOGY'(LENY - 1)) begin
                        rd_cnt_d = '0;
                        frames_d = frames_q + 16'd1;
                        state_d  = LOAD;
                    end else begin
                        rd_cnt_d = rd_cnt_q + LOGY'(1);
                    end
                end
            end
        endcase

        // A full y set seen while still sending is parked in y_full.
        if (y_fire) begin
            if (rx_cnt_q == LOGY'(LENY - 1)) begin
                rx_cnt_d = '0;
                if (state_q == COLLECT) begin
                    state_d = DRAIN;
                end else begin
                    y_full_d = 1'b1;
                end
            end else begin
                rx_cnt_d = rx_cnt_q + LOGY'(1);
            end
        end
    end

    // State register; reset discards any partial frame at once.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q  <= LOAD;
            ld_cnt_q <= '0;
            tx_cnt_q <= '0;
            rx_cnt_q <= '0;
            rd_cnt_q <= '0;
            frames_q <= '0;
            armed_q  <= 1'b0;
            y_full_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            ld_cnt_q <= ld_cnt_d;
            tx_cnt_q <= tx_cnt_d;
            rx_cnt_q <= rx_cnt_d;
            rd_cnt_q <= rd_cnt_d;
            frames_q <= frames_d;
            armed_q  <= armed_d;
            y_full_q <= y_full_d;
        end
    end

endmodule

// File: tb/tb_conv_stream_host.sv
// Bench for conv_stream_host with a behavioural conv engine
// (taps 10,7,3,4, result clamped to 0..127) attached.
module tb_conv_stream_host;

    localparam int F [4] = '{10, 7, 3, 4};

    logic       clk = 1'b0;
    logic       reset_n = 1'b0;
    logic [7:0] ld_data = '0;
    logic       ld_valid = 1'b0;
    logic       ld_ready;
    logic [7:0] m_data_out_x;
    logic       m_valid_x;
    logic       m_ready_x = 1'b0;
    logic [7:0] s_data_in_y = '0;
    logic       s_valid_y = 1'b0;
    logic       s_ready_y;
    logic [7:0] rd_data;
    logic       rd_valid;
    logic       rd_ready = 1'b0;
    logic [15:0] frames_done;

    int n_vec = 0;
    int n_err = 0;
    int stall = 0;
    int extra = 0;
    int rd_hold = 0;
    int flush_y = 0;
    int yack_cnt = 0;
    int xcnt = 0;

    int src_q [$];
    int ld_frame [$];
    int expx_q [$];
    int exp_q [$];
    int eng_x [$];
    int eng_y [$];
    int rd_log [$];
    int want [$];

    conv_stream_host dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .ld_data      (ld_data),
        .ld_valid     (ld_valid),
        .ld_ready     (ld_ready),
        .m_data_out_x (m_data_out_x),
        .m_valid_x    (m_valid_x),
        .m_ready_x    (m_ready_x),
        .s_data_in_y  (s_data_in_y),
        .s_valid_y    (s_valid_y),
        .s_ready_y    (s_ready_y),
        .rd_data      (rd_data),
        .rd_valid     (rd_valid),
        .rd_ready     (rd_ready),
        .frames_done  (frames_done)
    );

    always #5 clk = ~clk;

    task automatic check(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int conv1(input int xs [$], input int n);
        int s = 0;
        for (int k = 0; k < 4; k++) s += F[k] * xs[n + k];
        if (s > 127) s = 127;
        if (s < 0) s = 0;
        return s;
    endfunction

    function automatic int sx(input logic [7:0] v);
        return int'($signed(v));
    endfunction

    // Drive all inputs shortly after each rising edge.
    always @(posedge clk) begin
        #1;
        if (flush_y != 0) begin
            eng_y.delete();
            flush_y = 0;
        end
        ld_valid    = (src_q.size() > 0) && (stall == 0 || $urandom_range(1) == 1);
        ld_data     = (src_q.size() > 0) ? 8'(src_q[0]) : 8'h00;
        m_ready_x   = (stall == 0) || ($urandom_range(1) == 1);
        s_valid_y   = (eng_y.size() > 0) && (stall == 0 || $urandom_range(1) == 1);
        s_data_in_y = (eng_y.size() > 0) ? 8'(eng_y[0]) : 8'h00;
        rd_ready    = (rd_hold == 0) && (stall == 0 || $urandom_range(1) == 1);
    end

    // Transfers that will happen on the next rising edge; scoreboard.
    always @(negedge clk) begin
        if (reset_n) begin
            if (ld_valid && ld_ready) begin
                ld_frame.push_back(sx(ld_data));
                void'(src_q.pop_front());
                if (ld_frame.size() == 8) begin
                    foreach (ld_frame[i]) expx_q.push_back(ld_frame[i]);
                    for (int n = 0; n < 5; n++) exp_q.push_back(conv1(ld_frame, n));
                    ld_frame.delete();
                end
            end
            if (m_valid_x && m_ready_x) begin
                check("x_avail", int'(expx_q.size() > 0), 1);
                if (expx_q.size() > 0) check("x_fwd", sx(m_data_out_x), expx_q.pop_front());
                eng_x.push_back(sx(m_data_out_x));
                xcnt++;
                if (eng_x.size() >= 4) eng_y.push_back(conv1(eng_x, eng_x.size() - 4));
                if (eng_x.size() == 8) begin
                    if (extra != 0) begin
                        eng_y.push_back(85);
                        eng_y.push_back(102);
                    end
                    eng_x.delete();
                    xcnt = 0;
                end
            end
            if (s_valid_y && s_ready_y) begin
                void'(eng_y.pop_front());
                yack_cnt++;
            end
            if (rd_valid && rd_ready) begin
                check("rd_avail", int'(exp_q.size() > 0), 1);
                if (exp_q.size() > 0) check("rd_data", sx(rd_data), exp_q.pop_front());
                rd_log.push_back(sx(rd_data));
            end
        end
    end

    task automatic push_seq(input int v0, input int step);
        for (int i = 0; i < 8; i++) src_q.push_back(v0 + i * step);
    endtask

    task automatic wait_frames(input int tgt);
        int n = 0;
        while (int'(frames_done) != tgt && n < 3000) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("frames_done", int'(frames_done), tgt);
    endtask

    task automatic check_log(input string nm);
        check({nm, "_len"}, rd_log.size(), want.size());
        for (int i = 0; i < want.size() && i < rd_log.size(); i++)
            check(nm, rd_log[i], want[i]);
        rd_log.delete();
    endtask

    task automatic wipe_model();
        src_q.delete();
        ld_frame.delete();
        expx_q.delete();
        exp_q.delete();
        eng_x.delete();
        eng_y.delete();
        rd_log.delete();
        xcnt = 0;
    endtask

    initial begin
        int n;
        #12;
        check("rst_ld_ready", ld_ready, 0);
        check("rst_m_valid", m_valid_x, 0);
        check("rst_s_ready", s_ready_y, 0);
        check("rst_rd_valid", rd_valid, 0);
        check("rst_x_data", m_data_out_x, 0);
        check("rst_rd_data", rd_data, 0);
        check("rst_frames", frames_done, 0);
        @(negedge clk);
        reset_n = 1'b1;
        @(posedge clk);
        #3;
        check("ld_ready_up", ld_ready, 1);

        // Free-flowing single frame
        want = '{49, 73, 97, 121, 127};
        push_seq(1, 1);
        wait_frames(1);
        check_log("free");

        // Same frame with random stalls on every port
        stall = 50;
        push_seq(1, 1);
        wait_frames(2);
        check_log("stall");
        stall = 0;

        // Three frames back to back
        push_seq(1, 1);
        push_seq(0, 0);
        push_seq(-1, 0);
        wait_frames(5);
        want = '{49, 73, 97, 121, 127, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0};
        check_log("b2b");

        // Engine offers 7 y beats; only 5 may be taken
        extra = 1;
        yack_cnt = 0;
        push_seq(1, 1);
        n = 0;
        while (yack_cnt < 5 && n < 500) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("yack5", yack_cnt, 5);
        check("ovf_s_ready", s_ready_y, 0);
        check("ovf_drain", rd_valid, 1);
        wait_frames(6);
        check("yack_final", yack_cnt, 5);
        want = '{49, 73, 97, 121, 127};
        check_log("ovf");
        extra = 0;
        flush_y = 1;
        @(posedge clk);
        #3;

        // Reset while four x samples have gone out
        stall = 50;
        push_seq(1, 1);
        n = 0;
        while (!(xcnt == 4 && m_valid_x) && n < 500) begin
            @(posedge clk);
            #3;
            n++;
        end
        check("mid_tx4", xcnt, 4);
        reset_n = 1'b0;
        #1;
        check("mid_m_valid", m_valid_x, 0);
        check("mid_rd_valid", rd_valid, 0);
        check("mid_s_ready", s_ready_y, 0);
        check("mid_frames", frames_done, 0);
        stall = 0;
        wipe_model();
        @(posedge clk);
        #3;
        reset_n = 1'b1;
        @(posedge clk);
        #3;
        check("mid_ld_ready", ld_ready, 1);
        push_seq(1, 1);
        wait_frames(1);
        want = '{49, 73, 97, 121, 127};
        check_log("post_rst");

        // Readout held off for 20 cycles
        rd_hold = 1;
        push_seq(1, 1);
        n = 0;
        while (!rd_valid && n < 500) begin
            @(posedge clk);
            #3;
            n++;
        end
        for (int i = 0; i < 20; i++) begin
            @(posedge clk);
            #3;
            check("hold_valid", rd_valid, 1);
            check("hold_data", sx(rd_data), 49);
            check("hold_ld_ready", ld_ready, 0);
        end
        rd_hold = 0;
        wait_frames(2);
        check_log("hold");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/conv_stream_host.md
Name: conv_stream_host

Overview:
Host-side endpoint for the conv_* streaming engines. It accepts a LENX-sample frame on a load port and transmits it to the engine's x input, acting as the valid/ready transmitter. It then receives the engine's LENY y outputs into a result buffer, acting as the valid/ready receiver. Finally it presents the results on a readout port. It replaces bench-style drivers so that conv engines can be embedded in larger datapaths.

Parameters:
WIDTH, 8, sample width in bits (signed two's complement)
LENX, 8, samples per input frame
LENY, 5, results per frame (LENX-LENF+1 of the attached engine)
LOGX, 3, counter width for x indices, ceil(log2(LENX))+0 (must hold LENX-1)
LOGY, 3, counter width for y indices (must hold LENY-1)

Ports:
clk  in  1  clock, all state on rising edge
reset_n  in  1  asynchronous, active-low reset
ld_data  in  WIDTH  frame sample from upstream
ld_valid  in  1  ld_data valid
ld_ready  out  1  host can accept a load sample
m_data_out_x  out  WIDTH  sample to conv engine s_data_in_x
m_valid_x  out  1  to engine s_valid_x
m_ready_x  in  1  from engine s_ready_x
s_data_in_y  in  WIDTH  result from engine m_data_out_y
s_valid_y  in  1  from engine m_valid_y
s_ready_y  out  1  to engine m_ready_y
rd_data  out  WIDTH  result sample to downstream
rd_valid  out  1  rd_data valid
rd_ready  in  1  downstream accepts
frames_done  out  16  completed frames, wraps at 2^16

Behaviour:
- Transfer rule on every port: a transfer occurs on a rising edge with valid && ready both high.
- Valid outputs are registered or state-decoded and never depend combinationally on the same port's ready.
- Data is held stable while valid && !ready.
- Buffers: xbuf[LENX] and ybuf[LENY] are register arrays with a combinational read. No read latency.
- Reset (reset_n low, async):
  - state = LOAD; all counters = 0; frames_done = 0.
  - ld_ready = 0 during reset, 1 after the first edge in LOAD.
  - m_valid_x = 0, s_ready_y = 0, rd_valid = 0.
  - m_data_out_x and rd_data = 0. Buffer contents are don't-care.
- FSM states: LOAD, SEND, COLLECT, DRAIN.
- LOAD:
  - ld_ready = 1. Each transfer writes xbuf[ld_cnt] and increments ld_cnt.
  - On the transfer with ld_cnt == LENX-1: go to SEND next cycle, clear ld_cnt.
- SEND:
  - m_valid_x = 1, m_data_out_x = xbuf[tx_cnt]. Each transfer increments tx_cnt.
  - On the transfer with tx_cnt == LENX-1: go to COLLECT, clear tx_cnt. m_valid_x drops the next cycle.
  - s_ready_y = 1 already in SEND. y beats arriving early are accepted and counted as in COLLECT.
- COLLECT:
  - s_ready_y = 1. Each transfer writes ybuf[rx_cnt] and increments rx_cnt.
  - When rx_cnt reaches LENY (including beats taken in SEND): go to DRAIN, s_ready_y = 0.
  - Further s_valid_y is ignored (not acknowledged).
- DRAIN:
  - rd_valid = 1, rd_data = ybuf[rd_cnt]. Each transfer increments rd_cnt.
  - On the transfer with rd_cnt == LENY-1: go to LOAD, clear rd_cnt, increment frames_done (wrap 0xFFFF -> 0).
- Latency: first m_valid_x 1 cycle after the final load transfer; first rd_valid 1 cycle after the LENY-th y transfer.
- Stalls: any number of idle cycles (valid or ready low) on any port are tolerated with no loss, duplication or reordering.
- Width: samples are stored and forwarded verbatim. No arithmetic on data.
- Reset mid-frame: all state is discarded immediately, back to LOAD with counters 0. Partially loaded or partially collected data is never emitted.
- Illegal counts are unreachable. Counters compare against LENX-1 / LENY-1 with == only.

Decomposition:
- Package conv_host_pkg:
  - typedef enum logic [1:0] host_state_t {LOAD, SEND, COLLECT, DRAIN}
  - localparams for default WIDTH/LENX/LENY
- One sub-module is natural: host_frame_buf (parameterised WIDTH, DEPTH, LOGD; synchronous write port, combinational read port).
  - Instantiated twice: x buffer and y buffer.

Test Plan:
- Loopback with conv_8_4_8_3 (f = 10,7,3,4), all readies/valids always 1. Load x = 1..8 -> rd_data sequence 49, 73, 97, 121, 127 (saturated). frames_done = 1.
- Same frame with random ~50% stalls on ld_valid, m_ready_x, s_valid_y and rd_ready -> identical 5 outputs in order, no extras, no drops.
- Back-to-back 3 frames: x = 1..8, then eight 0s, then eight -1s -> outputs 49,73,97,121,127 / 0,0,0,0,0 / 0,0,0,0,0. frames_done = 3.
- Standalone engine model that asserts s_valid_y for 7 beats -> host acknowledges exactly 5. s_ready_y = 0 from the cycle after the 5th, and DRAIN is entered.
- Drop reset_n low while tx_cnt = 4 in SEND -> same cycle: m_valid_x = 0, rd_valid = 0, s_ready_y = 0. After release, ld_ready = 1 and a fresh frame 1..8 yields 49,73,97,121,127.
- Hold rd_ready = 0 for 20 cycles in DRAIN -> rd_valid stays 1 and rd_data stays 49 throughout. ld_ready stays 0.
